// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl: Trivium core sequencer (restart, warm-up, byte gathering, valid/ready stream).
// Define TRIVIUM_CTRL_REKEY_EN to restart the core every REKEY_BYTES accepted bytes.
module trivium_stream_ctrl #(
    parameter int WARMUP      = 1152,
    parameter int REKEY_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic       core_rst_n,
    output logic       core_en,
    input  logic       core_bit,
    output logic [7:0] ks_data,
    output logic       ks_valid,
    input  logic       ks_ready,
    output logic       busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WARM = 3'd2;
    localparam logic [2:0] S_GATH = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]  state, nxt;
    logic [15:0] wcnt;
    logic [3:0]  gcnt, ccnt;
    logic        cap, hs, last;

    assign core_rst_n = (state != S_IDLE) && (state != S_LOAD);
    assign core_en    = (state == S_WARM) || ((state == S_GATH) && (gcnt < 4'd8));
    assign ks_valid   = state == S_HOLD;
    assign busy       = state != S_IDLE;
    assign hs         = ks_valid && ks_ready;

`ifdef TRIVIUM_CTRL_REKEY_EN
    logic [15:0] bcnt;
    assign last = bcnt == 16'(REKEY_BYTES - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst)                  bcnt <= '0;
        else if (state == S_LOAD)  bcnt <= '0;
        else if (hs)               bcnt <= bcnt + 16'd1;
`else
    // REKEY_BYTES is at least 1, so streaming never re-keys here
    assign last = REKEY_BYTES == 0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  nxt = S_WARM;
            S_WARM:  nxt = (wcnt == 16'(WARMUP - 1)) ? S_GATH : S_WARM;
            S_GATH:  nxt = (cap && ccnt == 4'd7) ? S_HOLD : S_GATH;
            S_HOLD:  nxt = hs ? (last ? S_LOAD : S_GATH) : S_HOLD;
            default: nxt = S_IDLE;
        endcase
        if (stop) nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            gcnt    <= '0;
            ccnt    <= '0;
            cap     <= 1'b0;
            ks_data <= 8'h00;
        end else begin
            state <= nxt;
            cap   <= core_en && (state == S_GATH);
            wcnt  <= (state == S_WARM) ? wcnt + 16'd1 : 16'd0;
            gcnt  <= (state == S_GATH) ? gcnt + {3'd0, core_en} : 4'd0;
            // core_bit lags core_en by one cycle, so capture follows the registered enable
            if (state == S_GATH && cap) begin
                ks_data <= {ks_data[6:0], core_bit};
                ccnt    <= ccnt + 4'd1;
            end else if (state != S_GATH) begin
                ccnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// tb_trivium_stream_ctrl: directed vector bench with a counting core model.
module tb_trivium_stream_ctrl;
    localparam int W = 1152;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, ks_ready = 1'b0;
    logic       core_rst_n, core_en, core_bit, ks_valid, busy;
    logic [7:0] ks_data;
    logic [3:0] o;
    logic [15:0] n;
    int cyc = 0, errs = 0, checks = 0, c0, t;

    trivium_stream_ctrl #(.WARMUP(W), .REKEY_BYTES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .core_rst_n(core_rst_n), .core_en(core_en), .core_bit(core_bit),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign o = {core_rst_n, core_en, ks_valid, busy};

    // byte k after warm-up is B2 + 37*k, MSB generated first; warm-up bits alternate
    function automatic logic [7:0] eb(input int k);
        return 8'hB2 + 8'(k) * 8'h37;
    endfunction
    function automatic logic pbit(input int i);
        logic [7:0] b;
        if (i < W) return i[0];
        b = eb((i - W) / 8);
        return b[7 - (i - W) % 8];
    endfunction

    always_ff @(posedge clk)
        if (!core_rst_n) begin
            n        <= '0;
            core_bit <= 1'b0;
        end else if (core_en) begin
            n        <= n + 16'd1;
            core_bit <= pbit(int'(n));
        end

    typedef struct {int c; logic [3:0] o;} vec_t;
    vec_t tab[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic accept();
        ks_ready = 1'b1;
        t = cyc;
        @(negedge clk);
        ks_ready = 1'b0;
    endtask

    initial begin
        tab[0] = '{1,    4'b0001};
        tab[1] = '{2,    4'b1101};
        tab[2] = '{W+1,  4'b1101};
        tab[3] = '{W+2,  4'b1101};
        tab[4] = '{W+9,  4'b1101};
        tab[5] = '{W+10, 4'b1001};
        tab[6] = '{W+11, 4'b1011};
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(o), 32'h0);
        chk("reset_data", 32'(ks_data), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            at(c0 + tab[i].c);
            chk($sformatf("timeline_%0d", tab[i].c), 32'(o), 32'(tab[i].o));
        end
        chk("first_byte", 32'(ks_data), 32'hB2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall", {20'd0, o, ks_data}, {20'd0, 4'b1011, 8'hB2});
        end
        accept();
        at(t + 9);  chk("gap1_pre", 32'(ks_valid), 32'd0);
        at(t + 10); chk("byte1", {23'd0, ks_valid, ks_data}, {23'd0, 1'b1, eb(1)});
        accept();
        at(t + 10); chk("byte2", {23'd0, ks_valid, ks_data}, {23'd0, 1'b1, eb(2)});
        accept();
`ifdef TRIVIUM_CTRL_REKEY_EN
        at(t + 1);      chk("rekey_load", 32'(o), 32'b0001);
        at(t + W + 10); chk("rekey_pre", 32'(ks_valid), 32'd0);
        at(t + W + 11); chk("byte3", {23'd0, ks_valid, ks_data}, {23'd0, 1'b1, eb(0)});
`else
        at(t + 9);  chk("byte3_pre", 32'(ks_valid), 32'd0);
        at(t + 10); chk("byte3", {23'd0, ks_valid, ks_data}, {23'd0, 1'b1, eb(3)});
`endif
        begin
            logic [7:0] held;
            held = ks_data;
            ks_ready = 1'b1;
            stop = 1'b1;
            @(negedge clk);
            ks_ready = 1'b0;
            stop = 1'b0;
            chk("stop_hs", 32'(o), 32'h0);
            chk("idle_hold_data", 32'(ks_data), 32'(held));
        end
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        at(c0 + 502);
        chk("warm_mid", 32'(o), 32'b1101);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_warm", 32'(o), 32'h0);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        at(c0 + W + 10); chk("rewarm_pre", 32'(o), 32'b1001);
        at(c0 + W + 11); chk("rewarm_byte", {20'd0, o, ks_data}, {20'd0, 4'b1011, 8'hB2});
        accept();
        start = 1'b1;
        at(t + 4);
        chk("gather_start_ignored", 32'(o), 32'b1101);
        #2 rst = 1'b0;
        #1 chk("async_reset", {20'd0, o, ks_data}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_load", 32'(o), 32'b0001);
        @(negedge clk);
        chk("post_reset_warm", 32'(o), 32'b1101);
        start = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
